// File: rtl/mc_cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/EXEC/MEM/HALT control over a parametrised datapath,
// with a variable-latency request/acknowledge memory port.
module mc_cpu_core #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        state_dbg
);
    // Memory handshake: mem_req, mem_we, mem_addr and mem_wdata are registered and held
    // constant until an edge where mem_req && mem_ack; that edge completes the transfer and
    // mem_rdata is sampled on it. mem_ack while mem_req is low has no effect.

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SL   = 5'd5;
    localparam logic [4:0] OP_SR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_SUBI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_ANDI = 5'd10;
    localparam logic [4:0] OP_XORI = 5'd11;
    localparam logic [4:0] OP_SLI  = 5'd12;
    localparam logic [4:0] OP_SRI  = 5'd13;
    localparam logic [4:0] OP_GT   = 5'd14;
    localparam logic [4:0] OP_LT   = 5'd15;
    localparam logic [4:0] OP_EQ   = 5'd16;
    localparam logic [4:0] OP_BR   = 5'd17;
    localparam logic [4:0] OP_STW  = 5'd18;
    localparam logic [4:0] OP_LDW  = 5'd19;
    localparam logic [4:0] OP_BZ   = 5'd20;
    localparam logic [4:0] OP_BN   = 5'd21;
    localparam logic [4:0] OP_HALT = 5'd22;

    localparam int SH_W = $clog2(DATA_W);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [8];
    logic              flag_z;
    logic              flag_n;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    logic [4:0]        op;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] tgt;
    logic [DATA_W-1:0] b_op;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;
    logic              is_alu;
    logic              is_illegal;
    logic              taken;
    logic [ADDR_W-1:0] next_pc;

    assign op        = ir[15:11];
    assign rd        = ir[10:8];
    assign ra        = ir[7:5];
    assign rb        = ir[4:2];
    assign imm       = {{(DATA_W-5){1'b0}}, ir[4:0]};
    assign tgt       = ADDR_W'(ir[10:0]);
    assign is_alu    = (op <= OP_EQ);
    assign is_illegal = (op > OP_HALT);
    assign state_dbg = state;

    always_comb begin
        b_op    = (op >= OP_ADDI && op <= OP_SRI) ? imm : opb;
        shamt   = b_op[SH_W-1:0];
        alu_res = '0;
        case (op)
            OP_ADD, OP_ADDI: alu_res = opa + b_op;
            OP_SUB, OP_SUBI: alu_res = opa - b_op;
            OP_OR,  OP_ORI:  alu_res = opa | b_op;
            OP_AND, OP_ANDI: alu_res = opa & b_op;
            OP_XOR, OP_XORI: alu_res = opa ^ b_op;
            OP_SL,  OP_SLI:  alu_res = opa << shamt;
            OP_SR,  OP_SRI:  alu_res = opa >> shamt;
            OP_GT:           alu_res = {{(DATA_W-1){1'b0}}, (opa > b_op)};
            OP_LT:           alu_res = {{(DATA_W-1){1'b0}}, (opa < b_op)};
            OP_EQ:           alu_res = {{(DATA_W-1){1'b0}}, (opa == b_op)};
            default:         alu_res = '0;
        endcase
    end

    // pc already points past the current instruction, so an untaken branch just keeps it.
    always_comb begin
        taken   = (op == OP_BR) || (op == OP_BZ && flag_z) || (op == OP_BN && flag_n);
        next_pc = taken ? tgt : pc;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Only the first fetch after reset arrives here with no request raised.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir      <= mem_rdata[15:0];
                        pc      <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa   <= rf[ra];
                    opb   <= rf[rb];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_illegal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (op == OP_STW || op == OP_LDW) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_STW);
                        mem_addr  <= opa[ADDR_W-1:0];
                        mem_wdata <= opb;
                        state     <= S_MEM;
                    end else begin
                        if (is_alu) begin
                            rf[rd] <= alu_res;
                            flag_z <= (alu_res == '0);
                            flag_n <= alu_res[DATA_W-1];
                        end
                        pc       <= next_pc;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= next_pc;
                        state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (!mem_we) rf[rd] <= mem_rdata;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core (DATA_W=32): small programs run against a latency-configurable
// memory model; every completed memory transaction is matched against an expected queue.
module tb_mc_cpu_core;
    localparam int             DW  = 32;
    localparam int             AW  = 16;
    localparam logic [AW-1:0]  RPC = 16'h0020;
    localparam int             SBW = 1 + AW + DW;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  OR_ = 5'd2,  AND_ = 5'd3, XOR_ = 5'd4;
    localparam logic [4:0] SL  = 5'd5,  SR  = 5'd6,  ADDI = 5'd7, SUBI = 5'd8, ORI = 5'd9;
    localparam logic [4:0] SLI = 5'd12, SRI = 5'd13, GT = 5'd14,  LT = 5'd15,  EQ = 5'd16;
    localparam logic [4:0] BR  = 5'd17, STW = 5'd18, LDW = 5'd19, BZ = 5'd20,  BN = 5'd21;
    localparam logic [4:0] HALT = 5'd22;
    localparam logic [2:0] ST_FETCH = 3'd0, ST_MEM = 3'd3, ST_HALT = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          halted, illegal;
    logic [2:0]    state_dbg;

    logic [DW-1:0]  mem [0:1023];
    logic [SBW-1:0] exp_q[$];
    int             checks = 0;
    int             failures = 0;
    int             wait_cycles = 0;
    bit             stray_ack = 1'b0;
    int             n;

    mc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
        .CLK(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .illegal(illegal), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [4:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic logic [15:0] enc_j(input logic [4:0] op, input logic [10:0] tgt);
        return {op, tgt};
    endfunction

    // Upper half of instruction words carries junk: only the low 16 bits are the instruction.
    task automatic put(input int addr, input logic [15:0] w);
        mem[addr] = {16'hA5A5, w};
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic exp_fetch(input int addr);
        exp_q.push_back({1'b0, AW'(addr), {DW{1'b0}}});
    endtask

    task automatic exp_read(input int addr);
        exp_q.push_back({1'b0, AW'(addr), {DW{1'b0}}});
    endtask

    task automatic exp_write(input int addr, input logic [DW-1:0] data);
        exp_q.push_back({1'b1, AW'(addr), data});
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_state", state_dbg, ST_FETCH);
        chk("rst_pc", dut.pc, RPC);
        chk("rst_ir", dut.ir, 0);
        chk("rst_flags", {dut.flag_z, dut.flag_n}, 0);
        for (int i = 0; i < 8; i++) chk("rst_rf", dut.rf[i], 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check_reset_vals();
    endtask

    // From a negedge: wait for the first request, then count edges until halted.
    task automatic measure(output int cyc);
        int guard = 0;
        @(negedge clk);
        while (!mem_req && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("run_halted", halted, 1);
    endtask

    task automatic run_prog(output int cyc);
        reset = 1'b0;
        measure(cyc);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    // ---------------- memory responder + scoreboard ----------------
    initial begin : responder
        int            cnt;
        logic [AW-1:0] cap_addr;
        logic [DW-1:0] cap_wdata;
        logic          cap_we;
        logic [SBW-1:0] obs, exp;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (cnt == 0) begin
                    cap_addr = mem_addr;
                    cap_we = mem_we;
                    cap_wdata = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, cap_addr);
                    chk("hold_we", mem_we, cap_we);
                    if (cap_we) chk("hold_wdata", mem_wdata, cap_wdata);
                end
                if (cnt >= wait_cycles) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr[9:0]];
                    if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
                    obs = {mem_we, mem_addr, (mem_we ? mem_wdata : {DW{1'b0}})};
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_txn", obs, '1);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("sb_txn", obs, exp);
                    end
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = stray_ack;
                cnt = 0;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;

        // Zero-wait arithmetic and timing.
        wait_cycles = 0;
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd5));
        put(32'h21, enc_i(ADDI, 3'd2, 3'd0, 5'd3));
        put(32'h22, enc_r(SUB, 3'd3, 3'd1, 3'd2));
        put(32'h23, enc_j(HALT, 11'd0));
        for (int a = 32'h20; a <= 32'h23; a++) exp_fetch(a);
        run_prog(n);
        chk("t1_cycles", n, 12);
        chk("t1_r3", dut.rf[3], 2);
        chk("t1_z", dut.flag_z, 0);
        chk("t1_pc", dut.pc, RPC + 4);
        chk("t1_illegal", illegal, 0);
        @(negedge clk);
        chk("t1_req_after_halt", mem_req, 0);

        // 32-bit shift into the MSB.
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd1));
        put(32'h21, enc_i(SLI, 3'd1, 3'd1, 5'd31));
        put(32'h22, enc_j(HALT, 11'd0));
        for (int a = 32'h20; a <= 32'h22; a++) exp_fetch(a);
        run_prog(n);
        chk("t2_r1", dut.rf[1], 32'h8000_0000);
        chk("t2_n", dut.flag_n, 1);
        chk("t2_z", dut.flag_z, 0);

        // Wrap from zero plus the rest of the ALU and unsigned compares.
        do_reset();
        clear_mem();
        put(32'h20, enc_i(SUBI, 3'd2, 3'd0, 5'd1));
        put(32'h21, enc_i(SRI, 3'd3, 3'd2, 5'd28));
        put(32'h22, enc_i(ADDI, 3'd4, 3'd0, 5'd6));
        put(32'h23, enc_r(XOR_, 3'd5, 3'd3, 3'd4));
        put(32'h24, enc_r(AND_, 3'd6, 3'd3, 3'd4));
        put(32'h25, enc_r(OR_, 3'd7, 3'd5, 3'd6));
        put(32'h26, enc_r(SL, 3'd4, 3'd4, 3'd3));
        put(32'h27, enc_r(GT, 3'd1, 3'd2, 3'd3));
        put(32'h28, enc_r(LT, 3'd0, 3'd2, 3'd3));
        put(32'h29, enc_j(HALT, 11'd0));
        for (int a = 32'h20; a <= 32'h29; a++) exp_fetch(a);
        run_prog(n);
        chk("t3_r2_wrap", dut.rf[2], 32'hFFFF_FFFF);
        chk("t3_r3_sri", dut.rf[3], 32'hF);
        chk("t3_r4_sl", dut.rf[4], 32'h0003_0000);
        chk("t3_r5_xor", dut.rf[5], 32'h9);
        chk("t3_r6_and", dut.rf[6], 32'h6);
        chk("t3_r7_or", dut.rf[7], 32'hF);
        chk("t3_r1_gt", dut.rf[1], 1);
        chk("t3_r0_lt", dut.rf[0], 0);
        chk("t3_zn", {dut.flag_z, dut.flag_n}, 2'b10);
        chk("t3_pc", dut.pc, RPC + 10);

        // Store/load with three wait cycles per transaction.
        wait_cycles = 3;
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd16));
        put(32'h21, enc_i(SLI, 3'd1, 3'd1, 5'd2));
        put(32'h22, enc_i(ADDI, 3'd2, 3'd0, 5'd1));
        put(32'h23, enc_i(SLI, 3'd2, 3'd2, 5'd5));
        put(32'h24, enc_i(ORI, 3'd2, 3'd2, 5'd15));
        put(32'h25, enc_i(SLI, 3'd2, 3'd2, 5'd5));
        put(32'h26, enc_i(ORI, 3'd2, 3'd2, 5'd23));
        put(32'h27, enc_i(SLI, 3'd2, 3'd2, 5'd5));
        put(32'h28, enc_i(ORI, 3'd2, 3'd2, 5'd15));
        put(32'h29, enc_r(STW, 3'd0, 3'd1, 3'd2));
        put(32'h2A, enc_r(LDW, 3'd4, 3'd1, 3'd0));
        put(32'h2B, enc_j(HALT, 11'd0));
        for (int a = 32'h20; a <= 32'h29; a++) exp_fetch(a);
        exp_write(32'h40, 32'h0000_BEEF);
        exp_fetch(32'h2A);
        exp_read(32'h40);
        exp_fetch(32'h2B);
        run_prog(n);
        chk("t4_cycles", n, 80);
        chk("t4_r4", dut.rf[4], 32'h0000_BEEF);
        chk("t4_mem40", mem[32'h40], 32'h0000_BEEF);
        chk("t4_pc", dut.pc, RPC + 12);

        // Conditional branches, zero wait.
        wait_cycles = 0;
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd5));
        put(32'h21, enc_r(EQ, 3'd3, 3'd1, 3'd0));
        put(32'h22, enc_j(BZ, 11'h010));
        put(32'h23, enc_j(HALT, 11'd0));
        put(32'h10, enc_r(EQ, 3'd3, 3'd1, 3'd1));
        put(32'h11, enc_j(BZ, 11'h018));
        put(32'h12, enc_i(SUBI, 3'd4, 3'd0, 5'd1));
        put(32'h13, enc_j(BN, 11'h016));
        put(32'h14, enc_j(HALT, 11'd0));
        put(32'h16, enc_i(ADDI, 3'd5, 3'd0, 5'd1));
        put(32'h17, enc_j(BN, 11'h01A));
        put(32'h18, enc_j(BR, 11'h01C));
        put(32'h19, enc_j(HALT, 11'd0));
        put(32'h1A, enc_j(HALT, 11'd0));
        put(32'h1C, enc_j(HALT, 11'd0));
        exp_fetch(32'h20); exp_fetch(32'h21); exp_fetch(32'h22);
        exp_fetch(32'h10); exp_fetch(32'h11); exp_fetch(32'h12); exp_fetch(32'h13);
        exp_fetch(32'h16); exp_fetch(32'h17); exp_fetch(32'h18); exp_fetch(32'h1C);
        run_prog(n);
        chk("t5_r3_eq", dut.rf[3], 1);
        chk("t5_r4", dut.rf[4], 32'hFFFF_FFFF);
        chk("t5_r5", dut.rf[5], 1);
        chk("t5_pc", dut.pc, 16'h001D);

        // Illegal opcode trap.
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd7));
        put(32'h21, enc_r(5'd25, 3'd7, 3'd1, 3'd1));
        exp_fetch(32'h20);
        exp_fetch(32'h21);
        run_prog(n);
        chk("t6_illegal", illegal, 1);
        chk("t6_state", state_dbg, ST_HALT);
        chk("t6_r1", dut.rf[1], 7);
        chk("t6_r7", dut.rf[7], 0);
        chk("t6_pc", dut.pc, RPC + 2);
        chk("t6_zn", {dut.flag_z, dut.flag_n}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_req_low", mem_req, 0);
        end

        // Reset in the second wait cycle of a load, then a stray ack with no request.
        wait_cycles = 3;
        do_reset();
        clear_mem();
        put(32'h20, enc_i(ADDI, 3'd1, 3'd0, 5'd8));
        put(32'h21, enc_r(LDW, 3'd4, 3'd1, 3'd0));
        put(32'h22, enc_j(HALT, 11'd0));
        mem[8] = 32'h0000_1234;
        exp_fetch(32'h20);
        exp_fetch(32'h21);
        reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (state_dbg != ST_MEM && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t7_reached_mem", state_dbg, ST_MEM);
        @(negedge clk);
        reset = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("t7_r4_unchanged", dut.rf[4], 0);
        chk("t7_pc", dut.pc, RPC);
        chk("t7_state", state_dbg, ST_FETCH);
        chk("t7_sb_no_load", exp_q.size(), 0);
        @(negedge clk);
        chk("t7_req_dropped", mem_req, 0);
        exp_fetch(32'h20);
        exp_fetch(32'h21);
        exp_read(32'h08);
        exp_fetch(32'h22);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t7_stray_pc", dut.pc, RPC);
        chk("t7_stray_ir", dut.ir, 0);
        chk("t7_stray_state", state_dbg, ST_FETCH);
        @(negedge clk);
        stray_ack = 1'b0;
        measure(n);
        chk("t7_sb_drained", exp_q.size(), 0);
        chk("t7_r4_loaded", dut.rf[4], 32'h0000_1234);
        chk("t7_r1", dut.rf[1], 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multicycle CPU core: the next generation of the team's 16-bit multicycle CPU, generalised in datapath width and address width. It adds a request/acknowledge memory port that tolerates variable latency, Z/N-conditional branches, a HALT instruction and illegal-opcode trapping. It sits between the system memory/bus fabric and a top-level wrapper, and owns the PC, IR, register file, flags and the control FSM.

## Interface
- DATA_W, 16: register/ALU/memory data width; legal range 16..32.
- ADDR_W, 16: memory address width; must be ≤ DATA_W.
- RESET_PC, 0: PC value loaded on reset, ADDR_W bits.
- CLK  in  1  core clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset, sampled on the CLK rising edge.
- mem_req  out  1  memory transaction request; held high until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  ADDR_W  transaction address.
- mem_wdata  out  DATA_W  write data; valid when mem_req = 1 and mem_we = 1.
- mem_rdata  in  DATA_W  read data; sampled on the completing edge.
- mem_ack  in  1  transaction completes on an edge where mem_req && mem_ack; ack is allowed in the first request cycle (zero wait).
- halted  out  1  core stopped, by HALT or by an illegal opcode.
- illegal  out  1  sticky flag: an undefined opcode was decoded.

## Operation
- State: PC (ADDR_W), IR (16), 8×DATA_W register file R0..R7 (all writable), flags Z and N.
- Instruction format, taken from the low 16 bits of the fetched word: op = IR[15:11], rd = IR[10:8], ra = IR[7:5], rb = IR[4:2], imm5 = IR[4:0] zero-extended, tgt = IR[10:0] zero-extended.
- Opcodes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SL, 6 SR, 7 ADDI, 8 SUBI, 9 ORI, 10 ANDI, 11 XORI, 12 SLI, 13 SRI, 14 GT, 15 LT, 16 EQ, 17 BR, 18 STW, 19 LDW, 20 BZ, 21 BN, 22 HALT. Opcodes 23..31 are illegal.
- Register ops: R[rd] ← R[ra] op R[rb]. Immediate ops use imm5 in place of R[rb].
- Arithmetic wraps modulo 2^DATA_W. Shifts are logical; the shift amount is the low clog2(DATA_W) bits of the B operand.
- GT, LT and EQ are unsigned compares and write 1 or 0 to R[rd].
- Ops 0..16 update Z (result == 0) and N (result MSB). All other ops leave the flags unchanged.
- BR: PC ← tgt. BZ and BN: PC ← tgt if Z (or N) = 1, otherwise PC unchanged (already incremented).
- STW: mem[R[ra][ADDR_W-1:0]] ← R[rb]. LDW: R[rd] ← mem[R[ra][ADDR_W-1:0]].
- Illegal opcode: set illegal and halted; no architectural write.
- FSM states and transitions:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On ack: IR ← rdata[15:0], PC ← PC+1 (wraps at 2^ADDR_W), go to DECODE.
  - DECODE: read R[ra] and R[rb] into operand latches. Go to EXEC.
  - EXEC: ALU ops write back and go to FETCH. Branches update PC and go to FETCH. STW/LDW go to MEM. HALT or illegal go to HALT.
  - MEM: request held until ack. LDW writes R[rd] on the ack edge. Then go to FETCH.
  - HALT: absorbing; only reset exits.
- Address, write data and we are stable for the whole time mem_req is high.

## Timing
- Reset values: PC = RESET_PC, R0..R7 = 0, Z = N = 0, IR = 0, state FETCH, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, halted = 0, illegal = 0.
- mem_req is registered. It first rises in the cycle after reset deasserts.
- With zero-wait memory: ALU and branch instructions take 3 cycles (FETCH, DECODE, EXEC); STW and LDW take 4. Each memory wait cycle adds 1.
- A register written in EXEC or MEM is visible to the next instruction's DECODE; no hazard exists.
- mem_req drops in the cycle after the ack edge. No back-to-back request without an intervening DECODE cycle, except MEM→FETCH, which may re-raise mem_req immediately.
- mem_ack while mem_req = 0 is ignored.
- Reset mid-transaction (any state, including wait cycles): core returns to reset values on that edge and mem_req drops the next cycle. The memory side must tolerate an abandoned request.

## Test plan
- Zero-wait memory. Program: ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2; HALT → R3 = 2, Z = 0, halted after 12 cycles, PC = RESET_PC+4.
- DATA_W = 32. SLI R1 with R1 = 1 and imm 31 → R1 = 0x8000_0000, N = 1. Then SUBI R1,R1,... wrap from 0 → 0xFFFF_FFFF.
- Memory ack delayed 3 cycles. STW R2→[R1 = 0x40] then LDW R4←[0x40] with R2 = 0xBEEF → R4 = 0xBEEF, and mem_addr/mem_wdata held stable during every wait.
- EQ R3 producing 0 (Z = 1), then BZ to 0x010 → next fetch addr 0x010. Same sequence with Z = 0 → falls through to PC+1. BN is exercised symmetrically.
- Fetch opcode 25 → illegal = 1, halted = 1, registers and PC unchanged, mem_req stays 0.
- Assert reset during the second wait cycle of an LDW → R[rd] unchanged (0), next fetch from RESET_PC, late mem_ack ignored.
